// File: rtl/tick_generator.sv
// Stopwatch strobe generator: divides the master clock into the 1 Hz count tick, 2 Hz adjust
// tick, display-refresh tick and the adjust-mode blink level, all as registered enables/levels.
module tick_generator #(
   parameter int unsigned CNT_W     = 27,
   parameter int unsigned DIV_1HZ   = 100000000,
   parameter int unsigned DIV_2HZ   = 50000000,
   parameter int unsigned DIV_FAST  = 200000,
   parameter int unsigned DIV_BLINK = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pause,
   input  logic [1:0] adjust,
   output logic       tick_1hz,
   output logic       tick_2hz,
   output logic       tick_fast,
   output logic       blink
);

   localparam logic [CNT_W-1:0] MAX_1HZ   = CNT_W'(DIV_1HZ - 1);
   localparam logic [CNT_W-1:0] MAX_2HZ   = CNT_W'(DIV_2HZ - 1);
   localparam logic [CNT_W-1:0] MAX_FAST  = CNT_W'(DIV_FAST - 1);
   localparam logic [CNT_W-1:0] MAX_BLINK = CNT_W'(DIV_BLINK - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [1:0]       adjust_q;
   logic [CNT_W-1:0] cnt_1hz_q, cnt_1hz_d;
   logic [CNT_W-1:0] cnt_2hz_q, cnt_2hz_d;
   logic [CNT_W-1:0] cnt_fast_q, cnt_fast_d;
   logic [CNT_W-1:0] cnt_blink_q, cnt_blink_d;
   logic             tick_1hz_q, tick_1hz_d;
   logic             tick_2hz_q, tick_2hz_d;
   logic             tick_fast_q, tick_fast_d;
   logic             blink_q, blink_d;
   logic             adj_chg;

   // Any change of the 2-bit mode re-phases count and blink timing.
   assign adj_chg = (adjust != adjust_q);

   // Display refresh runs regardless of pause or adjust.
   always_comb begin
      cnt_fast_d  = cnt_fast_q + CNT_ONE;
      tick_fast_d = 1'b0;
      if (cnt_fast_q == MAX_FAST) begin
         cnt_fast_d  = '0;
         tick_fast_d = 1'b1;
      end
   end

   always_comb begin
      cnt_1hz_d  = cnt_1hz_q + CNT_ONE;
      tick_1hz_d = 1'b0;
      if (adj_chg) begin
         cnt_1hz_d = '0;
      end else if (pause) begin
         cnt_1hz_d = cnt_1hz_q;
      end else if (cnt_1hz_q == MAX_1HZ) begin
         cnt_1hz_d  = '0;
         tick_1hz_d = 1'b1;
      end
   end

   always_comb begin
      cnt_2hz_d  = cnt_2hz_q + CNT_ONE;
      tick_2hz_d = 1'b0;
      if (adj_chg) begin
         cnt_2hz_d = '0;
      end else if (pause) begin
         cnt_2hz_d = cnt_2hz_q;
      end else if (cnt_2hz_q == MAX_2HZ) begin
         cnt_2hz_d  = '0;
         tick_2hz_d = 1'b1;
      end
   end

   // Blink restarts lit on a mode change so the selected digit is visible at once.
   always_comb begin
      cnt_blink_d = cnt_blink_q + CNT_ONE;
      blink_d     = blink_q;
      if (adj_chg) begin
         cnt_blink_d = '0;
         blink_d     = 1'b1;
      end else if (cnt_blink_q == MAX_BLINK) begin
         cnt_blink_d = '0;
         blink_d     = ~blink_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         adjust_q    <= '0;
         cnt_1hz_q   <= '0;
         cnt_2hz_q   <= '0;
         cnt_fast_q  <= '0;
         cnt_blink_q <= '0;
         tick_1hz_q  <= 1'b0;
         tick_2hz_q  <= 1'b0;
         tick_fast_q <= 1'b0;
         blink_q     <= 1'b0;
      end else begin
         adjust_q    <= adjust;
         cnt_1hz_q   <= cnt_1hz_d;
         cnt_2hz_q   <= cnt_2hz_d;
         cnt_fast_q  <= cnt_fast_d;
         cnt_blink_q <= cnt_blink_d;
         tick_1hz_q  <= tick_1hz_d;
         tick_2hz_q  <= tick_2hz_d;
         tick_fast_q <= tick_fast_d;
         blink_q     <= blink_d;
      end
   end

   assign tick_1hz  = tick_1hz_q;
   assign tick_2hz  = tick_2hz_q;
   assign tick_fast = tick_fast_q;
   assign blink     = blink_q;

endmodule

// File: tb/tb_tick_generator.sv
// Bench for tick_generator: cycle model feeds a scoreboard queue, plus directed edge checks.
module tb_tick_generator;

   localparam int unsigned CW = 4;
   localparam int D1 = 8;
   localparam int D2 = 4;
   localparam int DF = 3;
   localparam int DB = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pause = 1'b0;
   logic [1:0] adjust = 2'd0;
   logic       tick_1hz, tick_2hz, tick_fast, blink;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0] sb_q[$];

   // Reference model state
   logic [1:0] m_adj = 2'd0;
   int         m_c1 = 0, m_c2 = 0, m_cf = 0, m_cb = 0;
   logic       m_t1 = 1'b0, m_t2 = 1'b0, m_tf = 1'b0, m_bl = 1'b0;

   tick_generator #(
      .CNT_W    (CW),
      .DIV_1HZ  (D1),
      .DIV_2HZ  (D2),
      .DIV_FAST (DF),
      .DIV_BLINK(DB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pause    (pause),
      .adjust   (adjust),
      .tick_1hz (tick_1hz),
      .tick_2hz (tick_2hz),
      .tick_fast(tick_fast),
      .blink    (blink)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic p, input logic [1:0] a);
      logic chg;
      if (r) begin
         m_adj = 2'd0; m_c1 = 0; m_c2 = 0; m_cf = 0; m_cb = 0;
         m_t1 = 1'b0; m_t2 = 1'b0; m_tf = 1'b0; m_bl = 1'b0;
      end else begin
         chg   = (a != m_adj);
         m_adj = a;
         if (m_cf == DF - 1) begin m_cf = 0; m_tf = 1'b1; end
         else begin m_cf++; m_tf = 1'b0; end
         m_t1 = 1'b0;
         if (chg) m_c1 = 0;
         else if (!p) begin
            if (m_c1 == D1 - 1) begin m_c1 = 0; m_t1 = 1'b1; end
            else m_c1++;
         end
         m_t2 = 1'b0;
         if (chg) m_c2 = 0;
         else if (!p) begin
            if (m_c2 == D2 - 1) begin m_c2 = 0; m_t2 = 1'b1; end
            else m_c2++;
         end
         if (chg) begin m_cb = 0; m_bl = 1'b1; end
         else if (m_cb == DB - 1) begin m_cb = 0; m_bl = ~m_bl; end
         else m_cb++;
      end
   endtask

   function automatic logic [3:0] outs();
      return {tick_1hz, tick_2hz, tick_fast, blink};
   endfunction

   // Drive one edge: push model expectation, clock, then pop and compare.
   task automatic cycle(input logic r, input logic p, input logic [1:0] a);
      logic [3:0] exp;
      rst = r; pause = p; adjust = a;
      model_step(r, p, a);
      sb_q.push_back({m_t1, m_t2, m_tf, m_bl});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", outs(), 4'bxxxx);
      end else begin
         exp = sb_q.pop_front();
         check_val("sb", outs(), exp);
      end
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 2'd0);
      cycle(1'b1, 1'b0, 2'd0);
      check_val("rst_outs", outs(), 4'b0000);
   endtask

   task automatic plan(input string tag, input logic t1, input logic t2, input logic tf,
                       input logic bl);
      check_val(tag, outs(), {t1, t2, tf, bl});
   endtask

   initial begin
      // 1: free run
      do_reset();
      for (int e = 1; e <= 24; e++) begin
         cycle(1'b0, 1'b0, 2'd0);
         plan("s1", e % 8 == 0, e % 4 == 0, e % 3 == 0, (e / 5) % 2 == 1);
      end

      // 2: pause over edges 3..10
      do_reset();
      for (int e = 1; e <= 24; e++) begin
         cycle(1'b0, (e >= 3 && e <= 10), 2'd0);
         plan("s2", (e == 16 || e == 24), (e == 12 || e == 16 || e == 20 || e == 24),
              e % 3 == 0, (e / 5) % 2 == 1);
      end

      // 3: adjust 0->1 at edge 6
      do_reset();
      for (int e = 1; e <= 20; e++) begin
         cycle(1'b0, 1'b0, (e >= 6) ? 2'd1 : 2'd0);
         plan("s3", e == 14, (e == 4 || e == 10 || e == 14 || e == 18), e % 3 == 0,
              (e < 6) ? (e == 5) : (((e - 6) / 5) % 2 == 0));
      end

      // 4: adjust change on the tick_1hz wrap edge
      do_reset();
      for (int e = 1; e <= 24; e++) begin
         cycle(1'b0, 1'b0, (e >= 8) ? 2'd2 : 2'd0);
         plan("s4", (e == 16 || e == 24), (e == 4 || e == 12 || e == 16 || e == 20 || e == 24),
              e % 3 == 0, (e < 5) ? 1'b0 : (e < 8) ? 1'b1 : (((e - 8) / 5) % 2 == 0));
      end

      // 5: adjust change while paused, pause released at edge 10
      do_reset();
      for (int e = 1; e <= 20; e++) begin
         cycle(1'b0, (e >= 5 && e <= 9), (e >= 6) ? 2'd3 : 2'd0);
         plan("s5", e == 17, (e == 4 || e == 13 || e == 17), e % 3 == 0,
              (e < 5) ? 1'b0 : (e == 5) ? 1'b1 : (((e - 6) / 5) % 2 == 0));
      end

      // 6: reset mid-count with an adjust change, then identical to free run
      do_reset();
      for (int e = 1; e <= 10; e++) cycle(1'b0, 1'b0, 2'd0);
      cycle(1'b1, 1'b0, 2'd3);
      check_val("s6_rst", outs(), 4'b0000);
      for (int e = 1; e <= 24; e++) begin
         cycle(1'b0, 1'b0, 2'd0);
         plan("s6", e % 8 == 0, e % 4 == 0, e % 3 == 0, (e / 5) % 2 == 1);
      end

      check_val("sb_drain", 4'(sb_q.size()), 4'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tick_generator.md
Name: tick_generator

Overview:
- Produces every timing strobe for the lab3 stopwatch from the single master clock.
- Outputs are the 1 Hz count tick, the 2 Hz adjust tick, the display-refresh tick and the adjust-mode blink level.
- Its tick outputs are what the downstream clock-select stage chooses between.
- All outputs are one-master-clock-cycle enables or registered levels, never derived clocks.
- Changing the adjust mode re-phases the count and blink timing, so the first tick after a mode switch is a full period away.

Parameters:
- CNT_W, 27, width of every internal divide counter.
- DIV_1HZ, 100000000, master cycles per tick_1hz (min 2).
- DIV_2HZ, 50000000, master cycles per tick_2hz (min 2).
- DIV_FAST, 200000, master cycles per tick_fast, the display digit-refresh strobe (min 2).
- DIV_BLINK, 25000000, master cycles per blink toggle (min 2).

Ports:
- clk  input  1  master clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- pause  input  1  1 = freeze the 1 Hz and 2 Hz counters.
- adjust  input  2  adjust mode; 0 = normal, nonzero = adjust select.
- tick_1hz  output  1  one-cycle strobe every DIV_1HZ cycles.
- tick_2hz  output  1  one-cycle strobe every DIV_2HZ cycles.
- tick_fast  output  1  one-cycle strobe every DIV_FAST cycles.
- blink  output  1  square-wave level, toggles every DIV_BLINK cycles.

Behaviour:
- Reset: when rst=1 at an edge, all counters go to 0, adjust_q goes to 0 and all outputs go to 0. rst overrides every other input.
- Counter rule, identical for each of the four counters:
  - Counter counts 0..DIV-1.
  - At an edge where cnt==DIV-1: cnt<=0 and the registered tick<=1. Otherwise cnt<=cnt+1 and tick<=0.
  - Timing: tick is high for exactly one cycle. The first tick occurs DIV edges after the first non-reset edge; ticks then repeat with period DIV.
  - For blink, the wrap toggles blink instead of pulsing a tick.
- pause=1:
  - cnt_1hz and cnt_2hz hold their value; tick_1hz and tick_2hz are 0.
  - tick_fast and blink keep running, so the display stays live.
  - Releasing pause resumes from the held count, with no extra or lost tick.
- Adjust change:
  - adjust_q is a register holding the previous adjust.
  - At an edge where adjust!=adjust_q: cnt_1hz, cnt_2hz and cnt_blink are cleared to 0; tick_1hz and tick_2hz are forced to 0 for that edge; blink is set to 1.
  - Any 2-bit change counts, including nonzero->nonzero and back to 0.
  - tick_fast is unaffected.
- Priority: rst > adjust change > pause > normal counting.
  - An adjust change while paused still clears the counters; the counters then hold at 0 while pause stays 1.
  - A wrap coinciding with an adjust change produces no tick.
- Phase: the 1 Hz and 2 Hz counters are independent. When DIV_1HZ=2*DIV_2HZ, every tick_1hz coincides with a tick_2hz after reset or resync, as long as pause is never asserted.
- Widths: each counter compare is a CNT_W-bit equality; DIV-1 must fit in CNT_W. No saturation; counters wrap only via the compare.
- Latency: outputs are registered, one edge after the counter condition.

Test Plan:
All scenarios use DIV_1HZ=8, DIV_2HZ=4, DIV_FAST=3, DIV_BLINK=5, CNT_W=4.
1. Reset then free run for 24 cycles -> tick_1hz high at edges 8, 16, 24; tick_2hz at 4, 8, 12, 16, 20, 24; tick_fast every 3rd edge; blink toggles at 5, 10, 15, 20; all outputs 0 while rst=1.
2. pause=1 during edges 3-10, otherwise free run -> no tick_1hz/tick_2hz during the pause; first tick_1hz at edge 16 and first tick_2hz at edge 12 (the paused edges are not counted); tick_fast unchanged.
3. adjust 0->1 at edge 6 -> blink=1 after edge 6; no tick_2hz at edge 8; next tick_2hz at edge 10 and tick_1hz at edge 14; blink toggles to 0 at edge 11.
4. adjust change exactly at a tick_1hz wrap edge (edge 8) -> tick_1hz and tick_2hz stay 0 at that edge; next tick_1hz 8 edges later.
5. adjust change while pause=1, pause released 4 edges later -> counters restart from 0 at release; first tick_2hz 4 edges after release.
6. rst asserted mid-count together with an adjust change -> every output 0 next cycle, adjust_q=0, timing identical to scenario 1 from the release.
